// File: rtl/cbx_param_cfg.sv
// -----------------------------------------------------------------------------
// cbx_param_cfg -- configurable connection block for one horizontal channel.
//
// The channel tracks pass straight through. A set of ipin muxes picks one track
// per grid input pin. The mux selects come from a serial configuration chain.
// Bits are shifted into a shadow chain. A commit copies a complete chain into
// the active register, so reloading never glitches the live routing.
//
// Ports
//   prog_clk    configuration clock; all state updates on its rising edge
//   pReset      synchronous active-high reset
//   ccff_en     shift enable for the configuration chain
//   ccff_head   serial configuration data in (enters chain[0])
//   cfg_commit  single-cycle request to copy the chain into the active image
//   chanx_in    channel tracks in
//   chanx_out   channel tracks out (combinational feed-through)
//   grid_pin    ipin mux outputs
//   ccff_tail   serial data out, chain[CHAIN_LEN-1], for daisy-chaining
//   cfg_ready   exactly CHAIN_LEN bits shifted since the last reset or commit
//   cfg_valid   the active register holds a committed image
//   cfg_err     sticky: rejected commit or out-of-range select committed
// -----------------------------------------------------------------------------
module cbx_param_cfg #(
  parameter int CHAN_W   = 18,
  parameter int NUM_IPIN = 11,
  parameter int MUX_SIZE = 6,
  parameter int STRIDE   = 2
) (
  input  logic                prog_clk,
  input  logic                pReset,
  input  logic                ccff_en,
  input  logic                ccff_head,
  input  logic                cfg_commit,
  input  logic [CHAN_W-1:0]   chanx_in,
  output logic [CHAN_W-1:0]   chanx_out,
  output logic [NUM_IPIN-1:0] grid_pin,
  output logic                ccff_tail,
  output logic                cfg_ready,
  output logic                cfg_valid,
  output logic                cfg_err
);

  localparam int SEL_W     = $clog2(MUX_SIZE);
  localparam int CHAIN_LEN = NUM_IPIN * SEL_W;
  localparam int MUX_PAD   = 1 << SEL_W;
  // The counter must be able to hold CHAIN_LEN+1, which marks an over-shift.
  localparam int CNT_W     = $clog2(CHAIN_LEN + 2);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CHAIN_LEN + 1);
  localparam logic [SEL_W:0]   MUX_LIM  = (SEL_W + 1)'(MUX_SIZE);

  logic [CHAIN_LEN-1:0] chain_q, chain_d;
  logic [CHAIN_LEN-1:0] active_q, active_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;

  logic [NUM_IPIN-1:0]  sel_bad;     // per-pin out-of-range select in the shadow chain
  logic                 commit_ok;
  logic                 commit_bad;

  assign chanx_out = chanx_in;
  assign ccff_tail = chain_q[CHAIN_LEN-1];
  assign cfg_ready = (count_q == CNT_FULL);
  assign cfg_valid = valid_q;
  assign cfg_err   = err_q;

  // A commit is honoured only with a complete image and no shift in the same cycle.
  assign commit_ok  = cfg_commit & ~ccff_en & cfg_ready;
  assign commit_bad = cfg_commit & ~commit_ok;

  // Ipin muxes. Each row is padded to a power of two with constant zeros.
  // As a result, a select at or above MUX_SIZE drives its pin low without any extra compare.
  for (genvar k = 0; k < NUM_IPIN; k++) begin : g_pin
    logic [SEL_W-1:0]   sel;
    logic [MUX_PAD-1:0] row;

    assign sel        = active_q[k*SEL_W +: SEL_W];
    assign sel_bad[k] = ({1'b0, chain_q[k*SEL_W +: SEL_W]} >= MUX_LIM);

    for (genvar j = 0; j < MUX_PAD; j++) begin : g_in
      if (j < MUX_SIZE) begin : g_track
        assign row[j] = chanx_in[(k*STRIDE + j) % CHAN_W];
      end else begin : g_pad
        assign row[j] = 1'b0;
      end
    end

    assign grid_pin[k] = valid_q & row[sel];
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a
    // value unassigned and no latch is inferred.
    chain_d  = chain_q;
    count_d  = count_q;
    active_d = active_q;
    valid_d  = valid_q;
    err_d    = err_q | commit_bad;

    if (ccff_en) begin
      chain_d[0] = ccff_head;
      for (int i = 1; i < CHAIN_LEN; i++) begin
        chain_d[i] = chain_q[i-1];
      end
    end

    if (commit_ok) begin
      // An accepted commit always has ccff_en=0, so it never races the counter increment.
      count_d  = '0;
      active_d = chain_q;
      valid_d  = 1'b1;
      err_d    = err_q | (|sel_bad);
    end else if (ccff_en && (count_q != CNT_SAT)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge prog_clk) begin
    // NOTE: state is written with non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (pReset) begin
      chain_q  <= '0;
      active_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      chain_q  <= chain_d;
      active_q <= active_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_cbx_param_cfg.sv
// -----------------------------------------------------------------------------
// tb_cbx_param_cfg -- directed self-checking bench for cbx_param_cfg (defaults).
// A behavioural model tracks the shadow chain (as a queue), active image, count
// and flags. The tail queue and the grid_pin queue act as scoreboards.
// Expected values are pushed when stimulus is driven and popped when the DUT
// output is sampled.
// -----------------------------------------------------------------------------
module tb_cbx_param_cfg;

  localparam int CHAN_W    = 18;
  localparam int NUM_IPIN  = 11;
  localparam int MUX_SIZE  = 6;
  localparam int STRIDE    = 2;
  localparam int SEL_W     = 3;
  localparam int CHAIN_LEN = 33;

  logic                prog_clk = 1'b0;
  logic                pReset;
  logic                ccff_en;
  logic                ccff_head;
  logic                cfg_commit;
  logic [CHAN_W-1:0]   chanx_in;
  logic [CHAN_W-1:0]   chanx_out;
  logic [NUM_IPIN-1:0] grid_pin;
  logic                ccff_tail;
  logic                cfg_ready;
  logic                cfg_valid;
  logic                cfg_err;

  always #5 prog_clk = ~prog_clk;

  cbx_param_cfg #(
    .CHAN_W  (CHAN_W),
    .NUM_IPIN(NUM_IPIN),
    .MUX_SIZE(MUX_SIZE),
    .STRIDE  (STRIDE)
  ) dut (
    .prog_clk  (prog_clk),
    .pReset    (pReset),
    .ccff_en   (ccff_en),
    .ccff_head (ccff_head),
    .cfg_commit(cfg_commit),
    .chanx_in  (chanx_in),
    .chanx_out (chanx_out),
    .grid_pin  (grid_pin),
    .ccff_tail (ccff_tail),
    .cfg_ready (cfg_ready),
    .cfg_valid (cfg_valid),
    .cfg_err   (cfg_err)
  );

  int checks   = 0;
  int failures = 0;

  // Model state
  logic [CHAIN_LEN-1:0] exp_active;
  logic                 exp_valid;
  logic                 exp_err;
  int                   exp_count;
  logic                 tail_sb[$];   // oldest first: tail_sb[0] models chain[32]
  logic [NUM_IPIN-1:0]  pin_sb[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NUM_IPIN-1:0] calc_pins(input logic [CHAIN_LEN-1:0] act,
                                                    input logic vld,
                                                    input logic [CHAN_W-1:0] ch);
    logic [NUM_IPIN-1:0] p;
    logic [SEL_W-1:0]    s;
    p = '0;
    for (int k = 0; k < NUM_IPIN; k++) begin
      s = act[k*SEL_W +: SEL_W];
      if (vld && (int'(s) < MUX_SIZE)) p[k] = ch[(k*STRIDE + int'(s)) % CHAN_W];
    end
    return p;
  endfunction

  function automatic logic [CHAIN_LEN-1:0] model_chain();
    logic [CHAIN_LEN-1:0] c;
    for (int i = 0; i < CHAIN_LEN; i++) c[CHAIN_LEN-1-i] = tail_sb[i];
    return c;
  endfunction

  function automatic logic has_bad_sel(input logic [CHAIN_LEN-1:0] img);
    logic bad;
    bad = 1'b0;
    for (int k = 0; k < NUM_IPIN; k++)
      if (int'(img[k*SEL_W +: SEL_W]) >= MUX_SIZE) bad = 1'b1;
    return bad;
  endfunction

  task automatic step();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic model_shift(input logic b);
    void'(tail_sb.pop_front());
    tail_sb.push_back(b);
    if (exp_count < CHAIN_LEN + 1) exp_count++;
  endtask

  task automatic drive_chanx(input string tag, input logic [CHAN_W-1:0] v);
    chanx_in = v;
    pin_sb.push_back(calc_pins(exp_active, exp_valid, v));
    #1;
    check({tag, ".chanx_out"}, 64'(chanx_out), 64'(v));
    check({tag, ".grid_pin"}, 64'(grid_pin), 64'(pin_sb.pop_front()));
  endtask

  task automatic check_status(input string tag);
    check({tag, ".ready"}, 64'(cfg_ready), 64'(exp_count == CHAIN_LEN));
    check({tag, ".valid"}, 64'(cfg_valid), 64'(exp_valid));
    check({tag, ".err"},   64'(cfg_err),   64'(exp_err));
    check({tag, ".count"}, 64'(dut.count_q), 64'(exp_count));
  endtask

  task automatic do_reset(input logic noisy);
    pReset     = 1'b1;
    ccff_en    = noisy;
    cfg_commit = noisy;
    ccff_head  = 1'b1;
    chanx_in   = CHAN_W'($urandom);
    #1;
    check("rst.chanx_out", 64'(chanx_out), 64'(chanx_in));
    step();
    pReset     = 1'b0;
    ccff_en    = 1'b0;
    cfg_commit = 1'b0;
    ccff_head  = 1'b0;
    exp_active = '0;
    exp_valid  = 1'b0;
    exp_err    = 1'b0;
    exp_count  = 0;
    tail_sb.delete();
    for (int i = 0; i < CHAIN_LEN; i++) tail_sb.push_back(1'b0);
    check("rst.tail", 64'(ccff_tail), 64'(0));
    check("rst.grid_pin", 64'(grid_pin), 64'(0));
    check_status("rst");
  endtask

  task automatic shift_bit(input logic b);
    ccff_head = b;
    ccff_en   = 1'b1;
    step();
    ccff_en   = 1'b0;
    model_shift(b);
    check("shift.tail", 64'(ccff_tail), 64'(tail_sb[0]));
  endtask

  // The first bit shifted ends up at chain[CHAIN_LEN-1], so send the MSB first.
  task automatic shift_image(input logic [CHAIN_LEN-1:0] img);
    for (int i = CHAIN_LEN - 1; i >= 0; i--) shift_bit(img[i]);
  endtask

  task automatic commit(input logic with_shift, input logic b);
    logic [CHAIN_LEN-1:0] img;
    img        = model_chain();
    cfg_commit = 1'b1;
    ccff_en    = with_shift;
    ccff_head  = b;
    step();
    cfg_commit = 1'b0;
    ccff_en    = 1'b0;
    if (!with_shift && exp_count == CHAIN_LEN) begin
      exp_active = img;
      exp_valid  = 1'b1;
      exp_count  = 0;
      if (has_bad_sel(img)) exp_err = 1'b1;
    end else begin
      exp_err = 1'b1;
      if (with_shift) model_shift(b);
    end
    check("commit.tail", 64'(ccff_tail), 64'(tail_sb[0]));
  endtask

  initial begin
    logic [CHAIN_LEN-1:0] img_a;
    logic [CHAIN_LEN-1:0] img_b;
    logic [CHAIN_LEN-1:0] img_c;
    logic [CHAN_W-1:0]    ch;

    pReset = 1'b1; ccff_en = 1'b0; ccff_head = 1'b0; cfg_commit = 1'b0; chanx_in = '0;

    // Image A: sel_0=2, sel_10=5, the rest cycle through legal selects.
    img_a = '0;
    for (int k = 0; k < NUM_IPIN; k++) img_a[k*SEL_W +: SEL_W] = SEL_W'((k + 1) % MUX_SIZE);
    img_a[0*SEL_W +: SEL_W]  = 3'd2;
    img_a[10*SEL_W +: SEL_W] = 3'd5;
    img_b = CHAIN_LEN'(33'h0_9249_2492);  // all selects = 2 or 4, legal
    img_c = img_a;
    img_c[3*SEL_W +: SEL_W] = 3'd7;

    // Reset, load A, commit
    do_reset(1'b0);
    drive_chanx("rst_pins", 18'h3ffff);
    shift_image(img_a);
    check_status("a.loaded");
    commit(1'b0, 1'b0);
    check_status("a.commit");
    for (int i = 0; i < 4; i++) begin
      ch = CHAN_W'($urandom);
      drive_chanx("a.pins", ch);
      check("a.pin0", 64'(grid_pin[0]), 64'(ch[2]));
      check("a.pin10", 64'(grid_pin[10]), 64'(ch[7]));
    end

    // Shadow B; active stays A, tail emits A bits 33 shifts later
    shift_image(img_b);
    check_status("b.shadow");
    for (int i = 0; i < 4; i++) drive_chanx("b.pins_old", CHAN_W'($urandom));
    drive_chanx("b.pins_ones", 18'h3ffff);

    // Under-shift: 32 bits
    do_reset(1'b0);
    for (int i = 0; i < CHAIN_LEN - 1; i++) shift_bit(1'($urandom));
    commit(1'b0, 1'b0);
    check_status("under");
    drive_chanx("under.pins", 18'h3ffff);

    // Over-shift: 34 bits
    do_reset(1'b0);
    shift_bit(1'b1);
    shift_image(img_a);
    commit(1'b0, 1'b0);
    check_status("over");

    // Out-of-range select on pin 3
    do_reset(1'b0);
    shift_image(img_c);
    commit(1'b0, 1'b0);
    check_status("bad_sel");
    for (int i = 0; i < 3; i++) begin
      drive_chanx("bad_sel.pins", CHAN_W'($urandom));
      check("bad_sel.pin3", 64'(grid_pin[3]), 64'(0));
    end
    drive_chanx("bad_sel.ones", 18'h3ffff);

    // Commit together with shift at count 33
    do_reset(1'b0);
    shift_image(img_a);
    commit(1'b1, 1'b1);
    check_status("commit_shift");

    // Reset mid-load at bit 20, with shift and commit also asserted
    do_reset(1'b0);
    for (int i = 0; i < 20; i++) shift_bit(img_a[CHAIN_LEN-1-i]);
    do_reset(1'b1);
    for (int i = 0; i < 13; i++) shift_bit(img_a[12-i]);
    check_status("midload.partial");

    // Full reload works afterwards
    do_reset(1'b0);
    shift_image(img_a);
    commit(1'b0, 1'b0);
    check_status("reload");
    drive_chanx("reload.pins", CHAN_W'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Time limit so the bench cannot hang.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cbx_param_cfg.md
CBX_PARAM_CFG -- requirements
Module: cbx_param_cfg

Interface
REQ-001 Parameter CHAN_W, default 18: number of horizontal channel tracks.
REQ-002 Parameter NUM_IPIN, default 11: number of grid input pins driven by the block.
REQ-003 Parameter MUX_SIZE, default 6, legal range 2..CHAN_W: number of inputs per ipin mux.
REQ-004 Parameter STRIDE, default 2: track offset between consecutive ipins.
REQ-005 Derived SEL_W = ceil(log2(MUX_SIZE)) and CHAIN_LEN = NUM_IPIN*SEL_W (defaults 3 and 33).
REQ-006 prog_clk  in  1  configuration clock; the block's only clock, all state on rising edge.
REQ-007 pReset  in  1  synchronous, active-high reset.
REQ-008 ccff_en  in  1  shift enable for the configuration chain.
REQ-009 ccff_head  in  1  serial configuration data in.
REQ-010 cfg_commit  in  1  single-cycle request to copy the chain into the active configuration.
REQ-011 chanx_in  in  CHAN_W  channel tracks in.
REQ-012 chanx_out  out  CHAN_W  channel tracks out.
REQ-013 grid_pin  out  NUM_IPIN  ipin mux outputs.
REQ-014 ccff_tail  out  1  serial configuration data out, for daisy-chaining.
REQ-015 cfg_ready  out  1  exactly CHAIN_LEN bits shifted since the last reset or commit.
REQ-016 cfg_valid  out  1  active configuration holds a committed value.
REQ-017 cfg_err  out  1  sticky error flag.

Function
REQ-018 chanx_out SHALL equal chanx_in combinationally at all times, including during reset.
REQ-019 The shift chain SHALL be CHAIN_LEN bits, chain[0..CHAIN_LEN-1].
REQ-020 With ccff_en=1, each edge SHALL do chain[0]<=ccff_head and chain[i]<=chain[i-1]; with ccff_en=0 the chain holds.
REQ-021 ccff_tail SHALL equal chain[CHAIN_LEN-1] (registered; no combinational path from ccff_head).
REQ-022 A saturating counter SHALL count shifted bits: it increments per ccff_en cycle up to CHAIN_LEN+1 and holds there.
REQ-023 cfg_ready SHALL be 1 iff count==CHAIN_LEN.
REQ-024 A commit is accepted when cfg_commit=1, ccff_en=0 and cfg_ready=1. The next edge SHALL: copy the chain into the active register; set cfg_valid=1; clear the count to 0.
REQ-025 A commit with cfg_ready=0 (under- or over-shift) SHALL be rejected. A rejected commit leaves the active register and cfg_valid unchanged, sets cfg_err, and leaves the count unchanged.
REQ-026 cfg_commit and ccff_en high in the same cycle SHALL be treated as a rejected commit. The shift still occurs.
REQ-027 Shifting after a commit SHALL NOT disturb the active configuration; it only shadows the next image.
REQ-028 Ipin k select sel_k SHALL be active[k*SEL_W +: SEL_W], with the LSB at the lowest index.
REQ-029 Mux input j of ipin k SHALL be chanx_in[(k*STRIDE + j) mod CHAN_W], for j = 0..MUX_SIZE-1.
REQ-030 grid_pin[k] SHALL be combinational from the active register and chanx_in.
REQ-031 grid_pin[k] SHALL equal the selected track when cfg_valid=1 and sel_k<MUX_SIZE; otherwise it is 0.
REQ-032 A commit containing any sel_k>=MUX_SIZE SHALL be accepted. It sets cfg_err on the same edge, and the affected pins output 0.
REQ-033 cfg_err SHALL clear only on pReset.

Reset
REQ-034 pReset=1 at an edge SHALL clear chain, active register, count, cfg_valid and cfg_err to 0. ccff_tail=0 and grid_pin=0 follow.
REQ-035 pReset SHALL take priority over ccff_en and cfg_commit in the same cycle.
REQ-036 pReset asserted mid-load SHALL discard partial shifting; a complete 33-bit reload is then required.

Verification (defaults)
REQ-037 Test: reset, then shift 33 bits so that sel_0=2 and sel_10=5, then commit.
  Required: cfg_ready=1 before the commit; cfg_valid=1 and count=0 after it; grid_pin[0] follows chanx_in[2]; grid_pin[10] follows chanx_in[7].
REQ-038 Test: shift 32 bits, then commit.
  Required: rejected, cfg_err=1, cfg_valid stays 0, grid_pin=0.
REQ-039 Test: shift 34 bits, then commit.
  Required: rejected, cfg_err=1, count held at 34.
REQ-040 Test: after a valid commit, shift a new image without committing, then toggle chanx_in.
  Required: grid_pin follows the old configuration; ccff_tail emits the old chain bits delayed by 33 cycles.
REQ-041 Test: commit an image with sel_3=7.
  Required: accepted, cfg_err=1, grid_pin[3]=0, other pins correct.
REQ-042 Test: assert cfg_commit and ccff_en together at count 33; separately, pulse pReset at shifted bit 20.
  Required: the first is rejected and count becomes 34; the reset returns all outputs to 0 and cfg_ready=0.
